// File: rtl/arbitro_mem_ram_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM.
// slave = arbiter side, master = requesters/RAM side.
interface arbitro_mem_ram_if;
    logic       req_a;
    logic       req_b;
    logic       we_a;
    logic       we_b;
    logic [6:0] addr_a;
    logic [6:0] addr_b;
    logic [7:0] wdata_a;
    logic [7:0] wdata_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       rvalid_a;
    logic       rvalid_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       busy;
    logic [7:0] mem_entrada;
    logic [6:0] mem_end_entrada;
    logic [6:0] mem_end_saida;
    logic       mem_escrita;
    logic [7:0] mem_saida;

    modport slave (
        input  req_a, req_b, we_a, we_b,
        input  addr_a, addr_b, wdata_a, wdata_b,
        input  mem_saida,
        output gnt_a, gnt_b, rvalid_a, rvalid_b,
        output rdata_a, rdata_b, busy,
        output mem_entrada, mem_end_entrada,
        output mem_end_saida, mem_escrita
    );

    modport master (
        output req_a, req_b, we_a, we_b,
        output addr_a, addr_b, wdata_a, wdata_b,
        output mem_saida,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b,
        input  rdata_a, rdata_b, busy,
        input  mem_entrada, mem_end_entrada,
        input  mem_end_saida, mem_escrita
    );
endinterface

// File: rtl/arbitro_mem_ram.sv
// Round-robin arbiter sharing one RAM between requesters A and B.
// All outputs are registered; next values come from the FSM comb process.
module arbitro_mem_ram #(
    parameter int LAT_LEITURA = 2
) (
    input  logic               clk,
    input  logic               rst,
    arbitro_mem_ram_if.slave   bus
);
    typedef enum logic [1:0] {
        OCIOSO,
        CONCEDE,
        ESPERA,
        RETORNO
    } estado_t;

    localparam int CW = (LAT_LEITURA > 2) ? $clog2(LAT_LEITURA) : 1;
    localparam logic [CW-1:0] CNT_FIM = CW'(LAT_LEITURA - 2);

    estado_t       r_estado, w_estado;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_prio_b, w_prio_b;
    logic          r_venc_b, w_venc_b;
    logic          r_we, w_we;
    logic          r_gnt_a, w_gnt_a;
    logic          r_gnt_b, w_gnt_b;
    logic          r_rvalid_a, w_rvalid_a;
    logic          r_rvalid_b, w_rvalid_b;
    logic [7:0]    r_rdata_a, w_rdata_a;
    logic [7:0]    r_rdata_b, w_rdata_b;
    logic          r_busy, w_busy;
    logic [7:0]    r_mem_entrada, w_mem_entrada;
    logic [6:0]    r_mem_end_ent, w_mem_end_ent;
    logic [6:0]    r_mem_end_sai, w_mem_end_sai;
    logic          r_mem_escrita, w_mem_escrita;

    logic          w_sel_b;
    logic          w_sel_we;
    logic [6:0]    w_sel_addr;
    logic [7:0]    w_sel_wdata;

    // B wins only when A is absent or B holds the round-robin priority
    always_comb begin
        w_sel_b     = bus.req_b & (~bus.req_a | r_prio_b);
        w_sel_we    = w_sel_b ? bus.we_b    : bus.we_a;
        w_sel_addr  = w_sel_b ? bus.addr_b  : bus.addr_a;
        w_sel_wdata = w_sel_b ? bus.wdata_b : bus.wdata_a;
    end

    always_comb begin
        w_estado      = r_estado;
        w_cnt         = r_cnt;
        w_prio_b      = r_prio_b;
        w_venc_b      = r_venc_b;
        w_we          = r_we;
        w_gnt_a       = 1'b0;
        w_gnt_b       = 1'b0;
        w_rvalid_a    = 1'b0;
        w_rvalid_b    = 1'b0;
        w_rdata_a     = r_rdata_a;
        w_rdata_b     = r_rdata_b;
        w_mem_entrada = r_mem_entrada;
        w_mem_end_ent = r_mem_end_ent;
        w_mem_end_sai = r_mem_end_sai;
        w_mem_escrita = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (bus.req_a | bus.req_b) begin
                    w_estado = CONCEDE;
                    w_venc_b = w_sel_b;
                    w_prio_b = ~w_sel_b;
                    w_we     = w_sel_we;
                    w_gnt_a  = ~w_sel_b;
                    w_gnt_b  = w_sel_b;
                    if (w_sel_we) begin
                        w_mem_escrita = 1'b1;
                        w_mem_end_ent = w_sel_addr;
                        w_mem_entrada = w_sel_wdata;
                    end else begin
                        w_mem_end_sai = w_sel_addr;
                    end
                end
            end
            CONCEDE: begin
                if (r_we) begin
                    w_estado = OCIOSO;
                end else begin
                    w_estado = ESPERA;
                    w_cnt    = '0;
                end
            end
            ESPERA: begin
                if (r_cnt == CNT_FIM) begin
                    w_estado = RETORNO;
                    if (r_venc_b) begin
                        w_rdata_b  = bus.mem_saida;
                        w_rvalid_b = 1'b1;
                    end else begin
                        w_rdata_a  = bus.mem_saida;
                        w_rvalid_a = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            RETORNO: begin
                w_estado = OCIOSO;
            end
            default: begin
                w_estado = OCIOSO;
            end
        endcase
        w_busy = (w_estado != OCIOSO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado      <= OCIOSO;
            r_cnt         <= '0;
            r_prio_b      <= 1'b0;
            r_venc_b      <= 1'b0;
            r_we          <= 1'b0;
            r_gnt_a       <= 1'b0;
            r_gnt_b       <= 1'b0;
            r_rvalid_a    <= 1'b0;
            r_rvalid_b    <= 1'b0;
            r_rdata_a     <= '0;
            r_rdata_b     <= '0;
            r_busy        <= 1'b0;
            r_mem_entrada <= '0;
            r_mem_end_ent <= '0;
            r_mem_end_sai <= '0;
            r_mem_escrita <= 1'b0;
        end else begin
            r_estado      <= w_estado;
            r_cnt         <= w_cnt;
            r_prio_b      <= w_prio_b;
            r_venc_b      <= w_venc_b;
            r_we          <= w_we;
            r_gnt_a       <= w_gnt_a;
            r_gnt_b       <= w_gnt_b;
            r_rvalid_a    <= w_rvalid_a;
            r_rvalid_b    <= w_rvalid_b;
            r_rdata_a     <= w_rdata_a;
            r_rdata_b     <= w_rdata_b;
            r_busy        <= w_busy;
            r_mem_entrada <= w_mem_entrada;
            r_mem_end_ent <= w_mem_end_ent;
            r_mem_end_sai <= w_mem_end_sai;
            r_mem_escrita <= w_mem_escrita;
        end
    end

    assign bus.gnt_a           = r_gnt_a;
    assign bus.gnt_b           = r_gnt_b;
    assign bus.rvalid_a        = r_rvalid_a;
    assign bus.rvalid_b        = r_rvalid_b;
    assign bus.rdata_a         = r_rdata_a;
    assign bus.rdata_b         = r_rdata_b;
    assign bus.busy            = r_busy;
    assign bus.mem_entrada     = r_mem_entrada;
    assign bus.mem_end_entrada = r_mem_end_ent;
    assign bus.mem_end_saida   = r_mem_end_sai;
    assign bus.mem_escrita     = r_mem_escrita;
endmodule
